// File: rtl/wide_serial_subtractor.sv
// ============================================================================
// Module      : wide_serial_subtractor
// Description : Multi-cycle WIDTH-bit subtractor, Diff = A - B - Bin, one
//               CHUNK-bit slice per clock, LSB slice first, valid/ready I/O.
//               Optional signed-overflow output under macro WIDE_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wide_serial_subtractor #(
    parameter int WIDTH = 100,
    parameter int CHUNK = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef WIDE_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICES = WIDTH / CHUNK;
    localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_width_check
            $error("wide_serial_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               borrow;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [IDX_W-1:0]   slice_base;
    logic [CHUNK:0]     slice_diff;

    // Operands shift right each CALC cycle, so the active slice is always in the low bits.
    assign slice_diff = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]}
                      - {{CHUNK{1'b0}}, borrow};
    assign slice_base = IDX_W'(cnt) * IDX_W'(CHUNK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            cnt       <= '0;
            borrow    <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
`ifdef WIDE_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= A;
                        b_sh     <= B;
                        borrow   <= Bin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    Diff[slice_base +: CHUNK] <= slice_diff[CHUNK-1:0];
                    borrow <= slice_diff[CHUNK];
                    a_sh   <= a_sh >> CHUNK;
                    b_sh   <= b_sh >> CHUNK;
                    if (cnt == LAST_CNT) begin
                        Bout      <= slice_diff[CHUNK];
`ifdef WIDE_SUB_OVF_EN
                        // On the last slice the low CHUNK bits hold the operand MSBs.
                        ovf       <= (a_sh[CHUNK-1] != b_sh[CHUNK-1]) &
                                     (slice_diff[CHUNK-1] != a_sh[CHUNK-1]);
`endif
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wide_serial_subtractor.sv
// Scoreboard bench for wide_serial_subtractor: driver pushes expected results,
// a negedge monitor pops and compares on every output handshake.
`default_nettype none

module tb_wide_serial_subtractor;

    localparam int W = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Bin = 1'b0;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Diff;
    logic          Bout;
`ifdef WIDE_SUB_OVF_EN
    logic          ovf;
`endif

    wide_serial_subtractor #(.WIDTH(W), .CHUNK(25)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout)
`ifdef WIDE_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bi;
        logic [W-1:0] exp_diff;
        logic         exp_bout;
        logic         exp_ovf;
        int           acc;
    } op_t;

    op_t q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    bit  rand_rdy = 1'b0;
    bit  fixed_rdy = 1'b1;
    bit  ov_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide arithmetic, unsigned for Diff/Bout, sign-extended for overflow.
    function automatic op_t make_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        op_t o;
        logic [W:0]   u;
        logic [W+1:0] s;
        u = {1'b0, a} - {1'b0, b} - (W+1)'(bi);
        s = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b} - (W+2)'(bi);
        o.a = a;
        o.b = b;
        o.bi = bi;
        o.exp_diff = u[W-1:0];
        o.exp_bout = u[W];
        o.exp_ovf  = !((s[W+1:W-1] == 3'b000) || (s[W+1:W-1] == 3'b111));
        o.acc = 0;
        return o;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev) begin
                if (q.size() == 0) chk("unexpected_out_valid", 128'(out_valid), 128'(0));
                else               chk("latency", 128'(cyc - q[0].acc), 128'(4));
            end
            if (out_valid && out_ready && q.size() != 0) begin
                op_t e;
                logic [W-1:0] sum;
                e = q.pop_front();
                chk("diff", 128'(Diff), 128'(e.exp_diff));
                chk("bout", 128'(Bout), 128'(e.exp_bout));
                sum = Diff + e.b + W'(e.bi);
                chk("adder_roundtrip", 128'(sum), 128'(e.a));
`ifdef WIDE_SUB_OVF_EN
                chk("ovf", 128'(ovf), 128'(e.exp_ovf));
`endif
            end
            ov_prev = out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        op_t o;
        int  t;
        @(posedge clk); #1;
        A = a; B = b; Bin = bi; in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 128'(in_ready), 128'(1));
                break;
            end
        end
        o = make_op(a, b, bi);
        o.acc = cyc + 1;
        q.push_back(o);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = {$urandom, $urandom, $urandom, $urandom};
        B = {$urandom, $urandom, $urandom, $urandom};
        Bin = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) chk("drain_timeout", 128'(q.size()), 128'(0));
    endtask

    logic [W-1:0] ones = '1;
    logic [W-1:0] p75;

    initial begin
        p75 = '0;
        p75[75] = 1'b1;

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_diff", 128'(Diff), 128'(0));
        chk("rst_bout", 128'(Bout), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        send(W'(5), W'(3), 1'b0);
        send('0, W'(1), 1'b0);
        send(ones, ones, 1'b1);
        drain();

        // Stall: result must hold while out_ready is low
        fixed_rdy = 1'b0;
        send(p75, W'(1), 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_diff", 128'(Diff), 128'(p75 - W'(1)));
            chk("hold_bout", 128'(Bout), 128'(0));
            chk("hold_in_ready", 128'(in_ready), 128'(0));
            chk("hold_out_valid", 128'(out_valid), 128'(1));
        end
        fixed_rdy = 1'b1;
        drain();

        // Async reset in the third CALC cycle
        send({$urandom, $urandom, $urandom, $urandom}, W'(7), 1'b1);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_rst_in_ready", 128'(in_ready), 128'(1));
        chk("async_rst_out_valid", 128'(out_valid), 128'(0));
        chk("async_rst_diff", 128'(Diff), 128'(0));
        chk("async_rst_bout", 128'(Bout), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_valid_after_rst", 128'(out_valid), 128'(0));
        send(W'(10), W'(4), 1'b1);
        drain();

        // Signed overflow corner: max positive minus -1
        send(ones >> 1, ones, 1'b0);
        drain();

        // Randomized traffic with consumer stalls
        rand_rdy = 1'b1;
        for (int n = 0; n < 500; n++) begin
            logic [127:0] ra, rb;
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 9) == 0) rb = ra;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(ra[W-1:0], rb[W-1:0], 1'($urandom));
        end
        drain();
        rand_rdy = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
